// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - burst memory responder: read/write engines over a word-addressed store
// Optional random stalls on both engines: define MEM_RESPONDER_RANDOM_STALL_EN.
module mem_responder #(
  parameter int MEM_ADDR_WIDTH = 14,
  parameter int READ_LATENCY   = 4,
  parameter int WBUF_DEPTH     = 16,
  parameter int DRAIN_INTERVAL = 1,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] mem_read_control_base,
  input  logic [ADDR_WIDTH-1:0] mem_read_control_length,
  input  logic                  mem_read_control_go,
  output logic                  mem_read_control_done,
  input  logic                  mem_read_user_re,
  output logic                  mem_read_user_available,
  output logic [DATA_WIDTH-1:0] mem_read_user_data,
  input  logic [ADDR_WIDTH-1:0] mem_write_control_base,
  input  logic [ADDR_WIDTH-1:0] mem_write_control_length,
  input  logic                  mem_write_control_go,
  output logic                  mem_write_control_done,
  input  logic                  mem_write_user_we,
  input  logic [DATA_WIDTH-1:0] mem_write_user_data,
  output logic                  mem_write_user_full
);

  localparam int DEPTH = 1 << MEM_ADDR_WIDTH;
  localparam int CNT_W = ADDR_WIDTH - 2;
  localparam int LAT_W = $clog2(READ_LATENCY + 1);
  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int DRN_W = $clog2(DRAIN_INTERVAL + 1);

  localparam logic [1:0] R_IDLE   = 2'd0;
  localparam logic [1:0] R_WAIT   = 2'd1;
  localparam logic [1:0] R_STREAM = 2'd2;
  localparam logic [0:0] W_IDLE   = 1'b0;
  localparam logic [0:0] W_ACTIVE = 1'b1;

  logic [DATA_WIDTH-1:0] store [DEPTH];
  logic [DATA_WIDTH-1:0] fifo  [WBUF_DEPTH];

  logic                      stall;
  logic [1:0]                r_state;
  logic [MEM_ADDR_WIDTH-1:0] r_addr;
  logic [CNT_W-1:0]          r_cnt;
  logic [LAT_W-1:0]          r_lat;
  logic                      r_avail;
  logic                      r_consume;
  logic [CNT_W-1:0]          r_len_words;

  logic [0:0]                w_state;
  logic [MEM_ADDR_WIDTH-1:0] w_addr;
  logic [CNT_W-1:0]          w_cnt;
  logic [CNT_W-1:0]          w_pushed;
  logic [CNT_W-1:0]          w_committed;
  logic [PTR_W-1:0]          w_wr_ptr;
  logic [PTR_W-1:0]          w_rd_ptr;
  logic [PTR_W:0]            w_occ;
  logic [DRN_W-1:0]          w_drain;
  logic                      w_full;
  logic                      w_push;
  logic                      w_commit;
  logic [CNT_W-1:0]          w_len_words;

  logic unused_bits;
  assign unused_bits = ^{mem_read_control_base[1:0], mem_read_control_base[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2],
                         mem_read_control_length[1:0], mem_write_control_base[1:0],
                         mem_write_control_base[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2], mem_write_control_length[1:0]};

`ifdef MEM_RESPONDER_RANDOM_STALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 16'hACE1;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign stall = lfsr[0];
`else
  assign stall = 1'b0;
`endif

  assign r_len_words = mem_read_control_length[ADDR_WIDTH-1:2];
  assign r_avail     = (r_state == R_STREAM) && !stall;
  assign r_consume   = r_avail && mem_read_user_re;

  assign mem_read_control_done   = (r_state == R_IDLE);
  assign mem_read_user_available = r_avail;
  // Asynchronous store read: a commit at edge N is seen from cycle N+1, same-cycle reads see old data.
  assign mem_read_user_data      = (r_state == R_STREAM) ? store[r_addr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_lat   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (mem_read_control_go && r_len_words != '0) begin
            r_addr <= mem_read_control_base[MEM_ADDR_WIDTH+1:2];
            r_cnt  <= r_len_words;
            if (READ_LATENCY > 1) begin
              r_state <= R_WAIT;
              r_lat   <= LAT_W'(READ_LATENCY - 2);
            end else begin
              r_state <= R_STREAM;
            end
          end
        end
        R_WAIT: begin
          if (r_lat == '0) r_state <= R_STREAM;
          else             r_lat   <= r_lat - LAT_W'(1);
        end
        R_STREAM: begin
          if (r_consume) begin
            r_addr <= r_addr + MEM_ADDR_WIDTH'(1);
            r_cnt  <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign w_len_words = mem_write_control_length[ADDR_WIDTH-1:2];
  assign w_full      = (w_occ == (PTR_W+1)'(WBUF_DEPTH));
  assign w_push      = (w_state == W_ACTIVE) && mem_write_user_we && !w_full && (w_pushed != w_cnt);
  assign w_commit    = (w_state == W_ACTIVE) && (w_occ != '0) && (w_drain == '0) && !stall;

  assign mem_write_control_done = (w_state == W_IDLE);
  assign mem_write_user_full    = w_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state     <= W_IDLE;
      w_addr      <= '0;
      w_cnt       <= '0;
      w_pushed    <= '0;
      w_committed <= '0;
      w_wr_ptr    <= '0;
      w_rd_ptr    <= '0;
      w_occ       <= '0;
      w_drain     <= '0;
    end else if (w_state == W_IDLE) begin
      if (mem_write_control_go && w_len_words != '0) begin
        w_state     <= W_ACTIVE;
        w_addr      <= mem_write_control_base[MEM_ADDR_WIDTH+1:2];
        w_cnt       <= w_len_words;
        w_pushed    <= '0;
        w_committed <= '0;
        w_drain     <= '0;
      end
    end else begin
      if (w_push) begin
        w_wr_ptr <= w_wr_ptr + PTR_W'(1);
        w_pushed <= w_pushed + CNT_W'(1);
      end
      // The drain timer restarts on every commit, spacing commits DRAIN_INTERVAL edges apart.
      if (w_commit) begin
        w_rd_ptr    <= w_rd_ptr + PTR_W'(1);
        w_addr      <= w_addr + MEM_ADDR_WIDTH'(1);
        w_committed <= w_committed + CNT_W'(1);
        w_drain     <= DRN_W'(DRAIN_INTERVAL - 1);
        if (w_committed + CNT_W'(1) == w_cnt) w_state <= W_IDLE;
      end else if (w_drain != '0) begin
        w_drain <= w_drain - DRN_W'(1);
      end
      case ({w_push, w_commit})
        2'b10:   w_occ <= w_occ + (PTR_W+1)'(1);
        2'b01:   w_occ <= w_occ - (PTR_W+1)'(1);
        default: w_occ <= w_occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)   fifo[w_wr_ptr] <= mem_write_user_data;
    if (w_commit) store[w_addr]  <= fifo[w_rd_ptr];
  end

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(mem_read_user_re && !r_avail))
        else $error("mem_responder: user_re without user_available ignored");
      assert (!(mem_read_control_go && r_state != R_IDLE))
        else $error("mem_responder: read control_go while busy ignored");
      assert (!(mem_write_control_go && w_state != W_IDLE))
        else $error("mem_responder: write control_go while busy ignored");
      assert (!(mem_write_user_we && w_full))
        else $error("mem_responder: push while write buffer full dropped");
      assert (!(mem_write_user_we && !w_full && !w_push))
        else $error("mem_responder: push outside an active burst dropped");
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed plus randomized checks of mem_responder against a shadow-store model
module tb_mem_responder;

  localparam int MAW   = 8;
  localparam int RL    = 4;
  localparam int WB    = 16;
  localparam int DI    = 8;
  localparam int DEPTH = 1 << MAW;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rd_base, rd_len, rd_data;
  logic        rd_go, rd_done, rd_re, rd_avail;
  logic [31:0] wr_base, wr_len, wr_data;
  logic        wr_go, wr_done, wr_we, wr_full;

  int vectors = 0;
  int errs    = 0;
  logic [31:0] shadow [DEPTH];

  always #5 clk = ~clk;

  mem_responder #(
    .MEM_ADDR_WIDTH(MAW), .READ_LATENCY(RL), .WBUF_DEPTH(WB), .DRAIN_INTERVAL(DI),
    .ADDR_WIDTH(32), .DATA_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read_control_base(rd_base), .mem_read_control_length(rd_len),
    .mem_read_control_go(rd_go), .mem_read_control_done(rd_done),
    .mem_read_user_re(rd_re), .mem_read_user_available(rd_avail), .mem_read_user_data(rd_data),
    .mem_write_control_base(wr_base), .mem_write_control_length(wr_len),
    .mem_write_control_go(wr_go), .mem_write_control_done(wr_done),
    .mem_write_user_we(wr_we), .mem_write_user_data(wr_data), .mem_write_user_full(wr_full)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag, input int got, input int want);
    vectors++;
    errs++;
    $error("FAIL %s: observed %0d words expected %0d", tag, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected read stream: nothing for RL-1 cycles, then shadow words in order, one per consumed beat.
  task automatic do_read(input int wbase, input int nwords, input bit hold, input int stop_after);
    int  k, left, consumed;
    bit  ea;
    rd_base = 32'(wbase * 4);
    rd_len  = 32'(nwords * 4);
    rd_go   = 1'b1;
    tick();
    rd_go    = 1'b0;
    k        = 1;
    left     = nwords;
    consumed = 0;
    for (int cyc = 0; cyc < nwords * 16 + RL + 8; cyc++) begin
      ea = (k >= RL) && (left > 0);
      check("rd_done", 32'(rd_done), 32'(left == 0));
      check("rd_avail", 32'(rd_avail), 32'(ea));
      if (ea) check("rd_data", rd_data, shadow[(wbase + consumed) % DEPTH]);
      if (left == 0 || consumed == stop_after) break;
      rd_re = ea && (hold || ($urandom_range(0, 1) == 1));
      tick();
      k++;
      if (rd_re) begin
        left--;
        consumed++;
      end
    end
    rd_re = 1'b0;
    if (left != 0 && consumed != stop_after) timeout("rd_timeout", consumed, nwords);
  endtask

  // Expected write behaviour: FIFO of pending words, commits spaced DI edges apart, full at WB entries.
  task automatic do_write(input int wbase, input int nwords, input bit always_push, input bit seq);
    int          occ, pushed, committed, t, last_commit;
    bit          push, commit;
    logic [31:0] d;
    logic [31:0] q[$];
    wr_base = 32'(wbase * 4);
    wr_len  = 32'(nwords * 4);
    wr_go   = 1'b1;
    tick();
    wr_go       = 1'b0;
    occ         = 0;
    pushed      = 0;
    committed   = 0;
    t           = 0;
    last_commit = -1000;
    for (int cyc = 0; cyc < nwords * (DI + 2) + 40; cyc++) begin
      check("wr_done", 32'(wr_done), 32'(committed == nwords));
      check("wr_full", 32'(wr_full), 32'(occ == WB));
      if (committed == nwords) break;
      push    = (pushed < nwords) && (occ < WB) && (always_push || ($urandom_range(0, 1) == 1));
      d       = seq ? 32'(pushed + 1) : $urandom;
      wr_we   = push;
      wr_data = d;
      t++;
      commit = (occ > 0) && (t - last_commit >= DI);
      if (commit) begin
        shadow[(wbase + committed) % DEPTH] = q.pop_front();
        committed++;
        last_commit = t;
      end
      if (push) begin
        q.push_back(d);
        pushed++;
      end
      occ = occ + int'(push) - int'(commit);
      tick();
    end
    wr_we = 1'b0;
    if (committed != nwords) timeout("wr_timeout", committed, nwords);
  endtask

  initial begin
    int b, n;
    rst_n   = 1'b0;
    rd_base = '0; rd_len = '0; rd_go = 1'b0; rd_re = 1'b0;
    wr_base = '0; wr_len = '0; wr_go = 1'b0; wr_we = 1'b0; wr_data = '0;
    tick(); tick(); tick();
    check("rst_rd_done", 32'(rd_done), 32'd1);
    check("rst_rd_avail", 32'(rd_avail), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_wr_done", 32'(wr_done), 32'd1);
    check("rst_wr_full", 32'(wr_full), 32'd0);
    rst_n = 1'b1;
    tick();

    do_write(32'h40, 4, 1'b0, 1'b0);
    do_read(32'h40, 4, 1'b1, -1);

    do_write(32'h80, 4, 1'b1, 1'b1);
    do_read(32'h80, 4, 1'b1, -1);
    check("seq_word0", shadow[32'h80], 32'd1);
    check("seq_word3", shadow[32'h83], 32'd4);

    do_write(32'h10, 16, 1'b1, 1'b0);
    do_write(32'h20, 32, 1'b1, 1'b0);
    do_read(32'h20, 32, 1'b0, -1);

    do_write(DEPTH - 1, 2, 1'b0, 1'b0);
    do_read(DEPTH - 1, 2, 1'b1, -1);

    do_read(32'h40, 4, 1'b1, 2);
    rst_n = 1'b0;
    #1;
    check("abort_avail", 32'(rd_avail), 32'd0);
    check("abort_done", 32'(rd_done), 32'd1);
    check("abort_data", rd_data, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    do_read(32'h40, 4, 1'b1, -1);

    rd_base = 32'h100; rd_len = '0; rd_go = 1'b1;
    wr_base = 32'h200; wr_len = '0; wr_go = 1'b1;
    tick();
    rd_go = 1'b0;
    wr_go = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("len0_rd_done", 32'(rd_done), 32'd1);
      check("len0_rd_avail", 32'(rd_avail), 32'd0);
      check("len0_wr_done", 32'(wr_done), 32'd1);
      check("len0_wr_full", 32'(wr_full), 32'd0);
      tick();
    end

    for (int i = 0; i < 6; i++) begin
      b = int'($urandom_range(0, DEPTH - 1));
      n = int'($urandom_range(1, 10));
      do_write(b, n, 1'b0, 1'b0);
      do_read(b, n, 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
